// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders plus an
// OR on the carries) sequenced LSB-first over WIDTH cycles, with a
// start/busy/done handshake.

// Half-adder stage used twice to form the full-adder cell.
module serial_add_ctrl_ha (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_p;
    logic             w_g;
    logic             w_s;
    logic             w_t;
    logic             w_c_nxt;

    // First half adder: propagate/generate of the two operand bits.
    serial_add_ctrl_ha u_ha0 (
        .i_x (r_sa[0]),
        .i_y (r_sb[0]),
        .o_s (w_p),
        .o_c (w_g)
    );

    // Second half adder folds in the running carry.
    serial_add_ctrl_ha u_ha1 (
        .i_x (w_p),
        .i_y (r_c),
        .o_s (w_s),
        .o_c (w_t)
    );

    assign w_c_nxt = w_g | w_t;
    assign w_last  = (r_cnt == LAST);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus handshake and datapath control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand/result shifting, carry and counter; outputs latched on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sr   <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_load) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sr  <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
            r_sr  <= {w_s, r_sr[WIDTH-1:1]};
            r_c   <= w_c_nxt;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= {w_s, r_sr[WIDTH-1:1]};
                r_cout <= w_c_nxt;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 addition; optional stray start pulse at RUN cycle index mid.
    task automatic add8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [7:0] es, input logic ec, input int mid);
        int cyc;
        int nb;
        int nd;
        @(negedge clk);
        a8 = ta; b8 = tb; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~ta; b8 = ~tb;
        cyc = 0; nb = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) nb++;
            cyc++;
            if (cyc == mid) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h11;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        check({tag, " busy_cycles"}, nb, 8);
        check({tag, " latency"}, cyc, 8);
        check({tag, " done"}, {31'd0, done8}, 1);
        check({tag, " sum"}, {24'd0, sum8}, {24'd0, es});
        check({tag, " cout"}, {31'd0, cout8}, {31'd0, ec});
        nd = 0;
        repeat (5) begin
            @(negedge clk);
            if (done8 === 1'b1) nd++;
        end
        check({tag, " extra_done"}, nd, 0);
        check({tag, " idle_busy"}, {31'd0, busy8}, 0);
        check({tag, " sum_hold"}, {24'd0, sum8}, {24'd0, es});
        check({tag, " cout_hold"}, {31'd0, cout8}, {31'd0, ec});
    endtask

    initial begin
        int prev;
        int pulses;
        int cyc;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy8}, 0);
        check("reset done", {31'd0, done8}, 0);
        check("reset sum", {24'd0, sum8}, 0);
        check("reset cout", {31'd0, cout8}, 0);
        rst = 1'b0;

        // Basic addition with a stray start mid-RUN that must be ignored.
        add8("35+4A", 8'h35, 8'h4A, 8'h7F, 1'b0, 3);

        // Reset during the 4th RUN cycle discards the addition.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid busy_before", {31'd0, busy8}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid busy", {31'd0, busy8}, 0);
        check("rst_mid done", {31'd0, done8}, 0);
        check("rst_mid sum", {24'd0, sum8}, 0);
        check("rst_mid cout", {31'd0, cout8}, 0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) pulses++;
        end
        check("rst_mid stays_idle", pulses, 0);
        add8("0F+01", 8'h0F, 8'h01, 8'h10, 1'b0, 0);

        add8("FF+01", 8'hFF, 8'h01, 8'h00, 1'b1, 0);
        add8("80+80", 8'h80, 8'h80, 8'h00, 1'b1, 0);
        add8("00+00", 8'h00, 8'h00, 8'h00, 1'b0, 0);
        add8("AA+55", 8'hAA, 8'h55, 8'hFF, 1'b0, 0);
        add8("C3+7E", 8'hC3, 8'h7E, 8'h41, 1'b1, 0);

        // Start held high: one result every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
        prev = -1; pulses = 0;
        for (int t = 0; t < 45; t++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                pulses++;
                check("held sum", {24'd0, sum8}, 32'h07);
                if (prev < 0) check("held first_latency", t, 8);
                else check("held period", t - prev, 10);
                prev = t;
            end
        end
        check("held pulses", pulses, 4);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        check("held idle_busy", {31'd0, busy8}, 0);

        // WIDTH=2 exhaustive.
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                @(negedge clk);
                a2 = 2'(ia); b2 = 2'(ib); start2 = 1'b1;
                @(negedge clk);
                start2 = 1'b0;
                cyc = 0;
                while (done2 !== 1'b1 && cyc < 10) begin
                    cyc++;
                    @(negedge clk);
                end
                check($sformatf("w2 %0d+%0d latency", ia, ib), cyc, 2);
                check($sformatf("w2 %0d+%0d result", ia, ib),
                      {29'd0, cout2, sum2}, 32'(ia + ib));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
